// File: rtl/draw_pkg.sv
// Shared definitions for the VGA drawing primitives (rectangles now,
// lines and sprites later).
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } draw_state_e;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic DRAW_FILL    = 1'b0;
  localparam logic DRAW_OUTLINE = 1'b1;

endpackage

// File: rtl/rect_scan_counter.sv
// Nested column/row counter for a row-major raster scan of a w x h area.
// On the final pixel both counters wrap to zero.
module rect_scan_counter #(
  parameter int DIM_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIM_W-1:0] w,
  input  logic [DIM_W-1:0] h,
  output logic [DIM_W-1:0] cx,
  output logic [DIM_W-1:0] cy,
  output logic             last
);

  logic [DIM_W-1:0] cx_q, cx_d;
  logic [DIM_W-1:0] cy_q, cy_d;
  logic             rowEnd;
  logic             colEnd;

  assign rowEnd = (cx_q == w - DIM_W'(1));
  assign colEnd = (cy_q == h - DIM_W'(1));
  assign last   = rowEnd && colEnd;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear) begin
      cx_d = '0;
      cy_d = '0;
    end else if (enable) begin
      if (rowEnd) begin
        cx_d = '0;
        cy_d = colEnd ? '0 : cy_q + DIM_W'(1);
      end else begin
        cx_d = cx_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx = cx_q;
  assign cy = cy_q;

endmodule

// File: rtl/rect_draw.sv
// Rectangle rasteriser: draws a filled or outline W x H box one pixel per
// clock at a latched origin/colour, clipping anything past the screen edge.
module rect_draw
  import draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int DIM_W    = 5,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [DIM_W-1:0]    w_in,
  input  logic [DIM_W-1:0]    h_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                outline,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  draw_state_e         state_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [DIM_W-1:0]    w_q;
  logic [DIM_W-1:0]    h_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                outline_q;

  logic [DIM_W-1:0]    cx;
  logic [DIM_W-1:0]    cy;
  logic                scanLast;
  logic                startReq;

  logic [X_W:0]        px;
  logic [Y_W:0]        py;
  logic                onScreen;
  logic                border;

  assign startReq = (state_q == IDLE) && go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      colour_q  <= '0;
      outline_q <= DRAW_FILL;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            x_q       <= x_in;
            y_q       <= y_in;
            w_q       <= w_in;
            h_q       <= h_in;
            colour_q  <= colour_in;
            outline_q <= outline;
            state_q   <= (w_in == '0 || h_in == '0) ? DONE : DRAW;
          end
        end
        DRAW: begin
          if (scanLast) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  rect_scan_counter #(
    .DIM_W(DIM_W)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (startReq),
    .enable (state_q == DRAW),
    .w      (w_q),
    .h      (h_q),
    .cx     (cx),
    .cy     (cy),
    .last   (scanLast)
  );

  // One extra bit on the adders so an off-screen pixel can never alias
  // back onto the visible area.
  assign px = {1'b0, x_q} + (X_W+1)'(cx);
  assign py = {1'b0, y_q} + (Y_W+1)'(cy);

  assign onScreen = (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H));
  assign border   = (cx == '0) || (cx == w_q - DIM_W'(1)) ||
                    (cy == '0) || (cy == h_q - DIM_W'(1));

  assign vga_x      = px[X_W-1:0];
  assign vga_y      = py[Y_W-1:0];
  assign vga_colour = colour_q;
  assign plot       = (state_q == DRAW) && onScreen && ((outline_q == DRAW_FILL) || border);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: doc/rect_draw.md
# rect_draw

Parametrised rectangle rasteriser for the VGA drawing path. Generalises the fixed 4x4 square drawer: it draws any W x H rectangle, filled or outline-only, at a latched origin and colour, one pixel per clock. Pixels that fall off-screen are clipped. It sits between game logic (sprites, notes, drum lane markers) and the VGA adapter's x/y/colour/plot inputs, and uses a go/busy/done handshake.

## Interface
- X_W, 8, screen x coordinate width
- Y_W, 7, screen y coordinate width
- COLOUR_W, 3, colour width
- DIM_W, 5, rectangle width/height field width (max 2^DIM_W-1 = 31)
- SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
- SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- go  in  1  start request; sampled only in IDLE
- x_in  in  X_W  origin x (top-left)
- y_in  in  Y_W  origin y
- w_in  in  DIM_W  width in pixels
- h_in  in  DIM_W  height in pixels
- colour_in  in  COLOUR_W  draw colour
- outline  in  1  1 = border pixels only, 0 = filled
- vga_x  out  X_W  pixel x
- vga_y  out  Y_W  pixel y
- vga_colour  out  COLOUR_W  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high in DRAW and DONE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: when go=1, latch x_in, y_in, w_in, h_in, colour_in and outline, and clear counters cx=cy=0.
  - If w_in==0 or h_in==0, go to DONE (no pixels).
  - Otherwise go to DRAW.
- DRAW: raster scan, row-major. cx increments each cycle. When cx==w-1, cx wraps to 0 and cy increments. When cx==w-1 and cy==h-1, go to DONE. DRAW lasts exactly w*h cycles.
- DONE: lasts one cycle with done=1, then returns to IDLE.
- Pixel address: px = x0+cx and py = y0+cy, computed at X_W+1 and Y_W+1 bits. vga_x and vga_y are the low X_W and Y_W bits.
- plot = (state==DRAW) && on_screen && (!outline || border).
  - on_screen = px<SCREEN_W && py<SCREEN_H.
  - border = cx==0 || cx==w-1 || cy==0 || cy==h-1.
- Clipped or interior pixels still consume their cycle. Scan length never depends on clipping.
- vga_colour is the latched colour at all times.
- go is ignored in DRAW and DONE. Input changes after latch have no effect.
- Reset, including mid-DRAW: state=IDLE on the next edge. All outputs take their reset values: plot=0, busy=0, done=0, vga_x=0, vga_y=0, vga_colour=0, latched registers=0.

## Timing
- go sampled at edge E0 leads to first pixel (cx=0, cy=0) valid with plot in cycle after E0.
- Last pixel is in cycle E0+w*h. done=1 in cycle E0+w*h+1. IDLE from E0+w*h+2.
- Degenerate size: done=1 in the cycle after E0, and plot is never asserted.
- Outputs are combinational from registered state and counters. There are no registers between counters and pins.
- Minimum go-to-go spacing is w*h+2 cycles. A go held high through DONE is accepted on its first IDLE cycle.

## Structure
- Package draw_pkg holds:
  - the state enum (IDLE/DRAW/DONE)
  - default SCREEN_W/SCREEN_H
  - the DRAW_FILL/DRAW_OUTLINE constants, shared with future line and sprite drawers
- Sub-module rect_scan_counter (parameter DIM_W): nested cx/cy counter.
  - Inputs: clear, enable, w, h.
  - Outputs: cx, cy, last.
- rect_draw holds the FSM, latches, address adders, clip/border logic.

## Test plan
- Fill: x=10, y=20, w=4, h=4, colour=3'b101, outline=0 -> 16 plot cycles, row-major (10,20)..(13,23), done on cycle 17 after go, busy low cycle 18.
- Outline: x=0, y=0, w=5, h=3 -> 15 DRAW cycles, plot on 12 border pixels, (1..3,1) not plotted, done on cycle 16.
- Clip: x=158, y=118, w=4, h=4 -> 16 DRAW cycles, plot only at (158..159, 118..119) = 4 pixels, vga_x never shows a wrapped value with plot=1.
- Degenerate: w=0, h=7 -> no plot, done the cycle after go. w=31, h=31 -> 961 DRAW cycles, last pixel (x+30, y+30).
- Handshake: go pulsed during DRAW with different colour -> ignored, colour unchanged. go held high continuously -> second rectangle starts exactly w*h+2 cycles after first go.
- Reset mid-DRAW at pixel 7 of a 4x4 -> next cycle plot=0, busy=0, done never pulses. A subsequent go draws the full 16 pixels from (x0, y0).
